// File: rtl/train_pkg.sv
// Shared types and limits for the training sequencer.
package train_pkg;

  localparam int TS_MAX_SETTLE = 15;
  localparam int TS_SETTLE_W   = $clog2(TS_MAX_SETTLE + 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SETTLE,
    UPDATE,
    NEXT,
    DONE
  } ts_state_t;

endpackage

// File: rtl/ts_counter.sv
// Loadable down-counter that stops at zero; term flags the zero count.
module ts_counter #(
  parameter int W = 4
) (
  input  logic         gclk,
  input  logic         grst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         term
);

  logic [W-1:0] count;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)                  count <= '0;
    else if (load)                count <= load_val;
    else if (en && count != '0)   count <= count - W'(1);
  end

  assign term = (count == '0);

endmodule

// File: rtl/train_sequencer.sv
// Steps a neuron through fetch/settle/update for every sample of every epoch.
// Optional macro TS_ERR_ACCUM_EN adds the per-epoch squared-error accumulator.
module train_sequencer
  import train_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int SAMPLE_AW     = 6,
  parameter int EPOCH_W       = 8
) (
  input  logic                 ts_clock,
  input  logic                 ts_reset_n,
  input  logic                 ts_start,
  input  logic [SAMPLE_AW:0]   ts_num_samples,
  input  logic [EPOCH_W-1:0]   ts_num_epochs,
  output logic                 ts_fetch_req,
  output logic [SAMPLE_AW-1:0] ts_sample_addr,
  input  logic                 ts_fetch_ack,
  input  real                  ts_target,
  input  real                  ts_axon,
  output real                  ts_backprop,
  output logic                 ts_update,
  output logic                 ts_busy,
  output logic                 ts_done,
  output real                  ts_epoch_err
);

  // The counter sits at SETTLE_CYCLES-1 on SETTLE entry, so SETTLE lasts SETTLE_CYCLES cycles.
  localparam logic [TS_SETTLE_W-1:0] SETTLE_INIT = TS_SETTLE_W'(SETTLE_CYCLES - 1);

  ts_state_t            state;
  logic [SAMPLE_AW:0]   ns_q;
  logic [EPOCH_W-1:0]   ne_q;
  logic [EPOCH_W-1:0]   epoch;
  logic [EPOCH_W-1:0]   epoch_nxt;
  logic [SAMPLE_AW:0]   addr_nxt;
  logic                 last_sample;
  logic                 settle_load;
  logic                 settle_term;
  real                  target_q;
`ifdef TS_ERR_ACCUM_EN
  real                  acc;
`endif

  assign addr_nxt    = {1'b0, ts_sample_addr} + (SAMPLE_AW+1)'(1);
  assign last_sample = (addr_nxt == ns_q);
  assign epoch_nxt   = epoch + EPOCH_W'(1);
  assign settle_load = (state == FETCH) && ts_fetch_ack;

  ts_counter #(.W(TS_SETTLE_W)) u_settle (
    .gclk     (ts_clock),
    .grst_n   (ts_reset_n),
    .load     (settle_load),
    .en       (state == SETTLE),
    .load_val (SETTLE_INIT),
    .term     (settle_term)
  );

  always_ff @(posedge ts_clock or negedge ts_reset_n) begin
    if (!ts_reset_n) begin
      state          <= IDLE;
      ns_q           <= '0;
      ne_q           <= '0;
      epoch          <= '0;
      target_q       <= 0.0;
      ts_fetch_req   <= 1'b0;
      ts_sample_addr <= '0;
      ts_backprop    <= 0.0;
      ts_update      <= 1'b0;
      ts_busy        <= 1'b0;
      ts_done        <= 1'b0;
`ifdef TS_ERR_ACCUM_EN
      acc            <= 0.0;
      ts_epoch_err   <= 0.0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (ts_start) begin
            ns_q           <= ts_num_samples;
            ne_q           <= ts_num_epochs;
            ts_sample_addr <= '0;
            epoch          <= '0;
`ifdef TS_ERR_ACCUM_EN
            acc            <= 0.0;
`endif
            if (ts_num_samples == '0 || ts_num_epochs == '0) begin
              state   <= DONE;
              ts_done <= 1'b1;
            end else begin
              state        <= FETCH;
              ts_fetch_req <= 1'b1;
              ts_busy      <= 1'b1;
              ts_done      <= 1'b0;
            end
          end
        end
        FETCH: begin
          if (ts_fetch_ack) begin
            target_q     <= ts_target;
            ts_fetch_req <= 1'b0;
            state        <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_term) begin
            ts_backprop <= target_q - ts_axon;
            ts_update   <= 1'b1;
            state       <= UPDATE;
          end
        end
        UPDATE: begin
          ts_update <= 1'b0;
`ifdef TS_ERR_ACCUM_EN
          acc       <= acc + ts_backprop * ts_backprop;
`endif
          state     <= NEXT;
        end
        NEXT: begin
          if (last_sample) begin
            ts_sample_addr <= '0;
            epoch          <= epoch_nxt;
`ifdef TS_ERR_ACCUM_EN
            ts_epoch_err   <= acc;
            acc            <= 0.0;
`endif
            if (epoch_nxt == ne_q) begin
              state   <= DONE;
              ts_busy <= 1'b0;
              ts_done <= 1'b1;
            end else begin
              state        <= FETCH;
              ts_fetch_req <= 1'b1;
            end
          end else begin
            ts_sample_addr <= addr_nxt[SAMPLE_AW-1:0];
            state          <= FETCH;
            ts_fetch_req   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef TS_ERR_ACCUM_EN
  assign ts_epoch_err = 0.0;
`endif

endmodule

// File: tb/tb_train_sequencer.sv
// Randomized scoreboard bench for train_sequencer: driver pushes expected updates, monitor pops them.
module tb_train_sequencer;

  localparam int S  = 2;
  localparam int AW = 6;
  localparam int EW = 8;

  logic          ts_clock = 1'b0;
  logic          ts_reset_n = 1'b0;
  logic          ts_start = 1'b0;
  logic          ts_fetch_ack = 1'b0;
  logic [AW:0]   ts_num_samples = '0;
  logic [EW-1:0] ts_num_epochs = '0;
  real           ts_target = 0.0;
  real           ts_axon = 0.0;
  logic          ts_fetch_req, ts_update, ts_busy, ts_done;
  logic [AW-1:0] ts_sample_addr;
  real           ts_backprop, ts_epoch_err;

  int     tests = 0;
  int     fails = 0;
  longint cyc = 0;
  int     upd_cnt = 0;
  int     exp_addr[$];
  real    exp_bp[$];
  longint upd_cyc[$];
  real    model_err = 0.0;
  int     mon_a;
  real    mon_b;

  train_sequencer #(.SETTLE_CYCLES(S), .SAMPLE_AW(AW), .EPOCH_W(EW)) dut (
    .ts_clock       (ts_clock),
    .ts_reset_n     (ts_reset_n),
    .ts_start       (ts_start),
    .ts_num_samples (ts_num_samples),
    .ts_num_epochs  (ts_num_epochs),
    .ts_fetch_req   (ts_fetch_req),
    .ts_sample_addr (ts_sample_addr),
    .ts_fetch_ack   (ts_fetch_ack),
    .ts_target      (ts_target),
    .ts_axon        (ts_axon),
    .ts_backprop    (ts_backprop),
    .ts_update      (ts_update),
    .ts_busy        (ts_busy),
    .ts_done        (ts_done),
    .ts_epoch_err   (ts_epoch_err)
  );

  always #5 ts_clock = ~ts_clock;
  always @(posedge ts_clock) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_r(input string name, input real act, input real exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %f expected %f (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic real rnd_val();
    return real'($urandom_range(0, 31)) / 8.0 - 2.0;
  endfunction

  // Monitor: every update pulse must match the oldest outstanding expectation.
  always @(negedge ts_clock) begin
    if (ts_reset_n && ts_update) begin
      upd_cnt++;
      upd_cyc.push_back(cyc);
      if (exp_bp.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_update: got addr %0d bp %f expected no update", ts_sample_addr, ts_backprop);
      end else begin
        mon_a = exp_addr.pop_front();
        mon_b = exp_bp.pop_front();
        chk("upd_addr", longint'(ts_sample_addr), longint'(mon_a));
        chk_r("upd_backprop", ts_backprop, mon_b);
      end
    end
  end

  task automatic pulse_start(input int ns, input int ne);
    @(negedge ts_clock);
    ts_num_samples = ns[AW:0];
    ts_num_epochs  = ne[EW-1:0];
    ts_start = 1'b1;
    @(negedge ts_clock);
    ts_start = 1'b0;
  endtask

  // Waits for a fetch request and answers it after a delay; returns 0 on timeout.
  task automatic serve(input int s, input int d, input bit fixed, output real bp, output bit ok);
    int  n;
    real t, a;
    n = 0;
    ok = 1'b1;
    while (!ts_fetch_req && n < 100) begin
      @(negedge ts_clock);
      n++;
    end
    if (!ts_fetch_req) begin
      chk("fetch_timeout", 0, 1);
      ok = 1'b0;
      bp = 0.0;
      return;
    end
    chk("fetch_addr", longint'(ts_sample_addr), longint'(s));
    repeat (d) begin
      @(negedge ts_clock);
      chk("wait_req", longint'(ts_fetch_req), 1);
      chk("wait_addr", longint'(ts_sample_addr), longint'(s));
    end
    t = fixed ? 1.0 : rnd_val();
    a = fixed ? 0.25 : rnd_val();
    bp = t - a;
    ts_target = t;
    ts_axon = a;
    ts_fetch_ack = 1'b1;
    exp_addr.push_back(s);
    exp_bp.push_back(bp);
    @(negedge ts_clock);
    ts_fetch_ack = 1'b0;
    ts_target = 99.0;  // target must have been captured at ack
  endtask

  task automatic run_train(input int ns, input int ne, input int dmin, input int dmax,
                           input bit poke, input bit fixed);
    int  c0, n;
    real bp, ep_sum;
    bit  ok;
    c0 = upd_cnt;
    pulse_start(ns, ne);
    if (ns == 0 || ne == 0) begin
      chk("zero_done", longint'(ts_done), 1);
      chk("zero_busy", longint'(ts_busy), 0);
      repeat (3) begin
        @(negedge ts_clock);
        chk("zero_no_fetch", longint'(ts_fetch_req), 0);
      end
      chk("zero_no_update", upd_cnt, c0);
      chk_r("zero_err", ts_epoch_err, model_err);
      return;
    end
    chk("start_busy", longint'(ts_busy), 1);
    chk("start_done_clr", longint'(ts_done), 0);
    for (int ep = 0; ep < ne; ep++) begin
      ep_sum = 0.0;
      for (int s = 0; s < ns; s++) begin
        serve(s, $urandom_range(dmin, dmax), fixed, bp, ok);
        if (!ok) return;
        ep_sum += bp * bp;
        if (poke && ep == 0 && s == 0) begin
          ts_num_samples = 7'd9;
          ts_num_epochs = 8'd5;
          ts_start = 1'b1;
          @(negedge ts_clock);
          ts_start = 1'b0;
          chk("poke_busy", longint'(ts_busy), 1);
        end
      end
`ifdef TS_ERR_ACCUM_EN
      model_err = ep_sum;
`endif
    end
    n = 0;
    while (!ts_done && n < 100) begin
      @(negedge ts_clock);
      n++;
    end
    chk("run_done", longint'(ts_done), 1);
    chk("run_busy_low", longint'(ts_busy), 0);
    chk_r("run_epoch_err", ts_epoch_err, model_err);
    chk("run_update_count", upd_cnt - c0, ns * ne);
    chk("run_queue_empty", exp_bp.size(), 0);
  endtask

  task automatic reset_test();
    int  c0;
    real bp;
    bit  ok;
    pulse_start(3, 1);
    for (int s = 0; s < 2; s++) begin
      serve(s, 0, 1'b0, bp, ok);
      if (!ok) return;
    end
    c0 = upd_cnt;
    #1 ts_reset_n = 1'b0;
    #1;
    chk("rst_fetch_req", longint'(ts_fetch_req), 0);
    chk("rst_update", longint'(ts_update), 0);
    chk("rst_busy", longint'(ts_busy), 0);
    chk("rst_done", longint'(ts_done), 0);
    chk("rst_addr", longint'(ts_sample_addr), 0);
    chk_r("rst_backprop", ts_backprop, 0.0);
    chk_r("rst_epoch_err", ts_epoch_err, 0.0);
    exp_addr.delete();
    exp_bp.delete();
    model_err = 0.0;
    repeat (3) @(negedge ts_clock);
    ts_reset_n = 1'b1;
    repeat (4) @(negedge ts_clock);
    chk("post_rst_busy", longint'(ts_busy), 0);
    chk("post_rst_done", longint'(ts_done), 0);
    chk("post_rst_fetch", longint'(ts_fetch_req), 0);
    chk("post_rst_no_update", upd_cnt, c0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("init_fetch_req", longint'(ts_fetch_req), 0);
    chk("init_update", longint'(ts_update), 0);
    chk("init_busy", longint'(ts_busy), 0);
    chk("init_done", longint'(ts_done), 0);
    chk("init_addr", longint'(ts_sample_addr), 0);
    chk_r("init_backprop", ts_backprop, 0.0);
    chk_r("init_epoch_err", ts_epoch_err, 0.0);
    @(negedge ts_clock);
    ts_reset_n = 1'b1;
    repeat (3) @(negedge ts_clock);
    chk("release_no_update", upd_cnt, 0);
    chk("release_idle_busy", longint'(ts_busy), 0);

    // two samples, immediate ack: updates spaced 1+S+2 cycles
    upd_cyc.delete();
    run_train(2, 1, 0, 0, 1'b0, 1'b1);
    if (upd_cyc.size() >= 2) chk("update_gap", upd_cyc[1] - upd_cyc[0], 1 + S + 2);
    else chk("update_gap_count", upd_cyc.size(), 2);

    run_train(2, 1, 3, 3, 1'b0, 1'b0);   // delayed ack
    run_train(3, 2, 0, 2, 1'b0, 1'b0);
    run_train(0, 3, 0, 0, 1'b0, 1'b0);
    run_train(4, 0, 0, 0, 1'b0, 1'b0);
    run_train(3, 1, 0, 1, 1'b1, 1'b0);   // start while busy
    reset_test();
    repeat (12) run_train($urandom_range(0, 5), $urandom_range(0, 3), 0, $urandom_range(0, 3),
                          1'($urandom_range(0, 1)), 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
